bus_req_dispatcher: RTL

Drains the coherence request FIFO and issues each entry as a MESI bus transaction. It sits between the request FIFO's read side and the shared snoop bus. It pops one 4-bit entry, decodes it into core id and bus opcode, and drives it on a valid/ready request channel. It then waits for the bus response, with a timeout.

---
 rtl/mesi_bus_pkg.sv | 30 +++
 rtl/resp_timer.sv | 41 ++++
 rtl/bus_req_dispatcher.sv | 118 +++++++++++
 3 files changed

// File: rtl/mesi_bus_pkg.sv
// Shared types for the MESI snoop-bus request path: bus opcodes, FIFO entry
// field positions and the dispatcher state encoding.
package mesi_bus_pkg;

  typedef enum logic [1:0] {
    BUS_RD    = 2'b00,
    BUS_RDX   = 2'b01,
    BUS_UPGR  = 2'b10,
    BUS_FLUSH = 2'b11
  } bus_op_e;

  localparam int CORE_MSB = 3;
  localparam int CORE_LSB = 2;
  localparam int OP_MSB   = 1;
  localparam int OP_LSB   = 0;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_POP       = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_ISSUE     = 3'd3,
    ST_WAIT_RESP = 3'd4
  } disp_state_e;

  // A Flush writes data back and completes on acceptance; everything else waits.
  function automatic logic needs_resp(input bus_op_e op);
    return (op != BUS_FLUSH);
  endfunction

endpackage

// File: rtl/resp_timer.sv
// Clearable up-counter with a terminal-count flag at TIMEOUT-1; bounds the
// time the dispatcher waits for a bus response.
module resp_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Next count: clear wins, then count up and hold at terminal count.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (en_i && (count_q != TC_VAL)) begin
      count_d = count_q + 8'd1;
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q == TC_VAL);

endmodule

// File: rtl/bus_req_dispatcher.sv
// Pops coherence requests from the FIFO one at a time, issues each on the
// snoop bus over valid/ready and waits (bounded) for its response.
module bus_req_dispatcher
  import mesi_bus_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             fifo_empty,
  input  logic [3:0]       fifo_data,
  output logic             fifo_rd_en,
  output logic             bus_req_valid,
  input  logic             bus_req_ready,
  output logic [1:0]       bus_req_core,
  output logic [1:0]       bus_req_op,
  input  logic             bus_resp_done,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] issued_cnt
);

  disp_state_e      state_q, state_d;
  logic [1:0]       core_q, core_d;
  bus_op_e          op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             hs_s;
  logic             tc_s;
  logic             in_wait_s;

  assign hs_s      = (state_q == ST_ISSUE) && bus_req_ready;
  assign in_wait_s = (state_q == ST_WAIT_RESP);

  // Held in clear outside WAIT_RESP so every wait starts from zero.
  resp_timer #(.TIMEOUT(TIMEOUT)) u_resp_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!in_wait_s),
    .en_i  (in_wait_s),
    .tc_o  (tc_s)
  );

  // Next-state, request latch, handshake count and sticky timeout.
  always_comb begin
    state_d = state_q;
    core_d  = core_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_POP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_POP: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        state_d = ST_ISSUE;
        core_d  = fifo_data[CORE_MSB:CORE_LSB];
        op_d    = bus_op_e'(fifo_data[OP_MSB:OP_LSB]);
      end
      ST_ISSUE: begin
        if (hs_s) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = needs_resp(op_q) ? ST_WAIT_RESP : ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_WAIT_RESP: begin
        // A done arriving together with the terminal count is a normal completion.
        if (bus_resp_done) begin
          state_d = ST_IDLE;
        end else if (tc_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_WAIT_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      core_q  <= 2'b00;
      op_q    <= BUS_RD;
      cnt_q   <= {CNT_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      core_q  <= core_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign fifo_rd_en    = (state_q == ST_POP);
  assign bus_req_valid = (state_q == ST_ISSUE);
  assign busy          = (state_q != ST_IDLE);
  assign bus_req_core  = core_q;
  assign bus_req_op    = op_q;
  assign timeout_err   = err_q;
  assign issued_cnt    = cnt_q;

endmodule
